if_fetch_ctrl: RTL and testbench
================================

# if_fetch_ctrl

Instruction-fetch controller that sequences the byte-addressed, combinationally-read instruction memory on behalf of the core. It owns the fetch PC, issues one word address per cycle, and buffers fetched words in a small queue. It hands instructions to decode over a valid/ready handshake and flushes and restarts on branch/jump redirects. It sits between the instruction memory and the decode stage.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset
- QUEUE_DEPTH, 2, fetch-queue entries (power of two, ≥2)
- MEM_BYTES, INSTR_MEM_SIZE, instruction memory size in bytes, used for range check

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- fetch_en  in  1  fetch permitted; 0 freezes PC and issues no pushes
- imem_addr  out  ADDR_WIDTH  byte address to instruction memory (always equals fetch PC)
- imem_rdata  in  DATA_WIDTH  instruction word, same-cycle combinational return
- redirect_valid  in  1  flush-and-restart request
- redirect_pc  in  ADDR_WIDTH  new fetch PC
- instr_valid  out  1  queue head valid
- instr_ready  in  1  decode accepts head
- instr_data  out  DATA_WIDTH  head instruction
- instr_pc  out  ADDR_WIDTH  head PC
- instr_fault  out  1  head is a fetch fault (misaligned or out of range)
- queue_count  out  $clog2(QUEUE_DEPTH)+1  occupied entries

## Operation

- State: fetch PC `fpc`, `fault_hold` flag, queue of {pc, data, fault}.
- Push condition per cycle: fetch_en & !fault_hold & !redirect_valid & (count<QUEUE_DEPTH | pop). Pop = instr_valid & instr_ready.
- Push writes {fpc, imem_rdata, 0} and fpc <= fpc+4 (modulo 2^ADDR_WIDTH).
- Fault check on fpc: fpc[1:0]!=0 or fpc > MEM_BYTES-4. A faulting push writes {fpc, NOP_INSTR, 1}, sets fault_hold, and leaves fpc unchanged. No further pushes until a redirect.
- Redirect (highest priority): queue emptied, fpc <= redirect_pc, fault_hold cleared, no push that cycle. A pop in the redirect cycle completes from decode's view but has no further effect.
- Queue outputs come directly from the head entry. instr_data/instr_pc/instr_fault are don't-care when instr_valid=0 and are driven 0 by the implementation.
- Push and pop in the same cycle with a full queue is legal; count is unchanged.

## Timing

- Reset values: fpc=RESET_PC, fault_hold=0, queue empty, instr_valid=0, instr_data/instr_pc/instr_fault=0, queue_count=0, imem_addr=RESET_PC.
- Fetch-to-valid latency: 1 cycle. The word addressed in cycle N appears at instr_valid in N+1.
- After reset release: first push in cycle 0 (if fetch_en=1), instr_valid=1 in cycle 1.
- Redirect in cycle R: imem_addr=redirect_pc in R+1, instr_valid for the target in R+2.
- Sustained throughput: 1 instruction/cycle while instr_ready=1.
- Backpressure: with instr_ready=0, the queue fills in QUEUE_DEPTH cycles and then fpc holds.
- Reset asserted mid-operation clears everything immediately (asynchronous); pending entries are lost.

## Structure

- Add to _riscv_defines: typedef fetch_entry_t {pc, data, fault}; constant NOP_INSTR = 32'h0000_0013.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t with push, pop, flush, count, and head outputs. Flush has priority over push.
- The top level holds fpc, fault_hold, fault check, and push logic.

## Test plan

- Reset release, fetch_en=1, instr_ready=1, mem words 0x00500093/0x00a00113 at 0/4 -> cycle 1 head {pc 0, 0x00500093}, cycle 2 {pc 4, 0x00a00113}, one per cycle.
- instr_ready=0 for 5 cycles -> queue_count saturates at 2, imem_addr holds at 8. Release -> pcs 0, 4, 8 in order with none lost or duplicated.
- Redirect to 0x40 while the queue is full -> next cycle count=0, imem_addr=0x40, cycle after: instr_valid with pc 0x40.
- Redirect to 0x42 -> single entry {pc 0x42, 0x00000013, fault 1}, then no further pushes. Redirect to 0x10 resumes normal fetch.
- Sequential fetch reaching MEM_BYTES-4, then MEM_BYTES -> last good word followed by fault entry at pc MEM_BYTES, then hold.
- Assert rst while count=2 and fetch mid-stream -> outputs immediately reset values, imem_addr=RESET_PC.

Source files
------------

// File: rtl/if_fetch_ctrl_pkg.sv
// rtl/if_fetch_ctrl_pkg.sv - shared types and constants for the instruction-fetch controller
package if_fetch_ctrl_pkg;

  localparam int ADDR_WIDTH     = 32;
  localparam int DATA_WIDTH     = 32;
  localparam int INSTR_MEM_SIZE = 256;

  // addi x0, x0, 0 : harmless filler carried by fault entries
  localparam logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] data;
    logic                  fault;
  } fetch_entry_t;

  // RUN: normal sequential fetch; HOLD: a fault entry was queued, wait for a redirect
  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HOLD = 1'b1
  } fetch_state_e;

  // A fetch faults when the PC is not word aligned or the word would run past memory
  function automatic logic addr_faults(input logic [ADDR_WIDTH-1:0] addr,
                                       input logic [ADDR_WIDTH-1:0] mem_bytes);
    return (addr[1:0] != 2'b00) || (addr > (mem_bytes - ADDR_WIDTH'(4)));
  endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// rtl/if_fetch_ctrl_if.sv - memory, redirect and decode handshake bundle of the fetch controller
interface if_fetch_ctrl_if
  import if_fetch_ctrl_pkg::*;
#(
  parameter int QUEUE_DEPTH = 2
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic                  fetch_en;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  instr_valid;
  logic                  instr_ready;
  logic [DATA_WIDTH-1:0] instr_data;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_fault;
  logic [CNT_W-1:0]      queue_count;

  // Fetch controller side
  modport master (
    input  fetch_en, imem_rdata, redirect_valid, redirect_pc, instr_ready,
    output imem_addr, instr_valid, instr_data, instr_pc, instr_fault, queue_count
  );

  // Core / memory / decode side
  modport slave (
    output fetch_en, imem_rdata, redirect_valid, redirect_pc, instr_ready,
    input  imem_addr, instr_valid, instr_data, instr_pc, instr_fault, queue_count
  );

endinterface

// File: rtl/if_fetch_ctrl_fetch_queue.sv
// rtl/if_fetch_ctrl_fetch_queue.sv - small synchronous FIFO of fetch entries with flush
module if_fetch_ctrl_fetch_queue
  import if_fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [CNT_W-1:0] count,
  output logic         head_valid,
  output fetch_entry_t head_entry
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Qualify requests: pop only when occupied, push only with room (a same-cycle pop frees one)
  always_comb begin
    do_pop  = pop & (count != '0);
    do_push = push & ((count < CNT_W'(DEPTH)) | do_pop);
  end

  // Pointer and occupancy bookkeeping; flush beats any push or pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful between rd_ptr and wr_ptr so no reset needed
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_entry;
  end

  // Head is presented straight from storage, zeroed when empty
  always_comb begin
    head_valid = (count != '0);
    head_entry = head_valid ? mem[rd_ptr] : '0;
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - fetch PC sequencing, fault detection and queue feed for decode
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 32'h0000_0000,
  parameter int                    QUEUE_DEPTH = 2,
  parameter int                    MEM_BYTES   = INSTR_MEM_SIZE
) (
  input logic           clk,
  input logic           rst,
  if_fetch_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] fpc;
  fetch_state_e          state;
  fetch_state_e          state_next;
  logic                  fault_now;
  logic                  pop;
  logic                  push;
  fetch_entry_t          push_entry;
  logic [CNT_W-1:0]      count;
  logic                  head_valid;
  fetch_entry_t          head_entry;

  // Push decision and the entry to enqueue for the current fetch PC
  always_comb begin
    fault_now  = addr_faults(fpc, ADDR_WIDTH'(MEM_BYTES));
    pop        = head_valid & bus.instr_ready;
    push       = bus.fetch_en & (state == FETCH_RUN) & ~bus.redirect_valid
               & ((count < CNT_W'(QUEUE_DEPTH)) | pop);
    push_entry = fault_now ? '{pc: fpc, data: NOP_INSTR, fault: 1'b1}
                           : '{pc: fpc, data: bus.imem_rdata, fault: 1'b0};
  end

  // Fault-hold state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH_RUN;
    else     state <= state_next;
  end

  // Redirect always releases the hold; a queued fault entry enters it
  always_comb begin
    state_next = state;
    if (bus.redirect_valid)    state_next = FETCH_RUN;
    else if (push & fault_now) state_next = FETCH_HOLD;
  end

  // Fetch PC: redirect wins, otherwise advance only on a good push
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    fpc <= RESET_PC;
    else if (bus.redirect_valid) fpc <= bus.redirect_pc;
    else if (push & ~fault_now) fpc <= fpc + ADDR_WIDTH'(4);
  end

  if_fetch_ctrl_fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (bus.redirect_valid),
    .count      (count),
    .head_valid (head_valid),
    .head_entry (head_entry)
  );

  // Drive the bundle from the fetch PC and the queue head
  always_comb begin
    bus.imem_addr   = fpc;
    bus.instr_valid = head_valid;
    bus.instr_data  = head_entry.data;
    bus.instr_pc    = head_entry.pc;
    bus.instr_fault = head_entry.fault;
    bus.queue_count = count;
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - directed self-checking bench for if_fetch_ctrl
module tb_if_fetch_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   passed;
  int   failed;

  if_fetch_ctrl_if #(.QUEUE_DEPTH(2)) bus ();

  if_fetch_ctrl #(
    .RESET_PC    (32'h0000_0000),
    .QUEUE_DEPTH (2),
    .MEM_BYTES   (256)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0)      return 32'h0050_0093;
    if (addr == 32'h4)      return 32'h00a0_0113;
    if (addr < 32'd256)     return 32'hA000_0000 | addr;
    return 32'hDEAD_BEEF;
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc,
                          input logic [31:0] data, input logic fault);
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
    chk({tag, "_pc"},    bus.instr_pc, pc);
    chk({tag, "_data"},  bus.instr_data, data);
    chk({tag, "_fault"}, 32'(bus.instr_fault), 32'(fault));
  endtask

  task automatic chk_empty(input string tag, input logic [31:0] addr);
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
    chk({tag, "_count"}, 32'(bus.queue_count), 32'd0);
    chk({tag, "_addr"},  bus.imem_addr, addr);
  endtask

  task automatic redirect(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    step();
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    failed = 0;
    rst                = 1'b1;
    bus.fetch_en       = 1'b1;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    // Reset state
    step();
    step();
    chk_empty("rst", 32'h0);
    chk("rst_data",  bus.instr_data, 32'h0);
    chk("rst_pc",    bus.instr_pc, 32'h0);
    chk("rst_fault", 32'(bus.instr_fault), 32'd0);

    // First fetches after release, one per cycle
    rst = 1'b0;
    step();
    chk_head("f0", 32'h0, 32'h0050_0093, 1'b0);
    chk("f0_addr", bus.imem_addr, 32'h4);
    step();
    chk_head("f1", 32'h4, 32'h00a0_0113, 1'b0);
    chk("f1_count", 32'(bus.queue_count), 32'd1);

    // Backpressure: queue fills, PC holds
    bus.instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("bp_count", 32'(bus.queue_count), 32'd2);
    chk("bp_addr",  bus.imem_addr, 32'hC);
    chk_head("bp_head", 32'h4, 32'h00a0_0113, 1'b0);
    bus.instr_ready = 1'b1;
    step();
    chk_head("rel0", 32'h8, 32'hA000_0008, 1'b0);
    chk("rel0_count", 32'(bus.queue_count), 32'd2);
    step();
    chk_head("rel1", 32'hC, 32'hA000_000C, 1'b0);

    // Redirect with a full queue
    bus.instr_ready = 1'b0;
    step();
    chk("full_count", 32'(bus.queue_count), 32'd2);
    redirect(32'h40);
    chk_empty("rd40", 32'h40);
    bus.instr_ready = 1'b1;
    step();
    chk_head("rd40_head", 32'h40, 32'hA000_0040, 1'b0);

    // Misaligned target: single fault entry, then hold
    redirect(32'h42);
    chk_empty("rd42", 32'h42);
    step();
    chk_head("mis", 32'h42, 32'h0000_0013, 1'b1);
    chk("mis_addr", bus.imem_addr, 32'h42);
    step();
    chk_empty("mis_hold0", 32'h42);
    step();
    chk_empty("mis_hold1", 32'h42);

    // Redirect clears the hold
    redirect(32'h10);
    chk_empty("rd10", 32'h10);
    step();
    chk_head("rd10_head", 32'h10, 32'hA000_0010, 1'b0);

    // End of memory: last good word, then range fault at MEM_BYTES
    redirect(32'hF8);
    step();
    chk_head("end0", 32'hF8, 32'hA000_00F8, 1'b0);
    step();
    chk_head("end1", 32'hFC, 32'hA000_00FC, 1'b0);
    step();
    chk_head("end_fault", 32'h100, 32'h0000_0013, 1'b1);
    chk("end_addr", bus.imem_addr, 32'h100);
    step();
    chk_empty("end_hold", 32'h100);

    // fetch_en low freezes fetch
    bus.fetch_en = 1'b0;
    redirect(32'h30);
    step();
    step();
    chk_empty("fe_off", 32'h30);
    bus.fetch_en = 1'b1;
    step();
    chk_head("fe_on", 32'h30, 32'hA000_0030, 1'b0);

    // Asynchronous reset mid-stream with a full queue
    bus.instr_ready = 1'b0;
    step();
    chk("pre_rst_count", 32'(bus.queue_count), 32'd2);
    rst = 1'b1;
    #1;
    chk_empty("arst", 32'h0);
    chk("arst_data",  bus.instr_data, 32'h0);
    chk("arst_pc",    bus.instr_pc, 32'h0);
    chk("arst_fault", 32'(bus.instr_fault), 32'd0);
    step();
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
